// File: rtl/uart_rx_stream.sv
// uart_rx_stream
//   UART receiver: asynchronous serial line in, parallel word out on a
//   valid/ready stream. Frame format: one start bit, DATA_AMOUNT data bits
//   sent LSB first, no parity, one stop bit. Each bit is sampled at its centre.
//   A start bit that has gone high again by its centre sample is rejected as a
//   glitch. Framing errors and overruns are each reported as a one-cycle pulse.
//
//   Ports:
//     clk_i        system clock, rising edge
//     rst_ni       asynchronous active-low reset
//     rxd_i        raw serial line, idle high, asynchronous to clk_i
//     data_o       received word, stable while valid_o=1
//     valid_o      data_o holds an unconsumed word
//     ready_i      consumer accepts; a transfer happens when valid_o & ready_i
//     busy_o       frame reception in progress
//     frame_err_o  one-cycle pulse: stop bit sampled low
//     overrun_o    one-cycle pulse: a completed word was dropped because the
//                  holding register was full
module uart_rx_stream #(
  parameter int unsigned CLK_KHZ     = 50000,
  parameter int unsigned BODS        = 9600,
  parameter int unsigned DATA_AMOUNT = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rxd_i,
  output logic [DATA_AMOUNT-1:0] data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   busy_o,
  output logic                   frame_err_o,
  output logic                   overrun_o
);

  localparam int unsigned DIV   = (CLK_KHZ * 1000 + BODS / 2) / BODS;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned IDX_W = (DATA_AMOUNT > 1) ? $clog2(DATA_AMOUNT) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_AMOUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic [1:0]             sync_q, sync_d;
  logic                   rxs;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_AMOUNT-1:0] shift_q, shift_d;
  logic [DATA_AMOUNT-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   tick;
  logic                   word_done;

  // Two-flop synchronizer; rxs is the only view of the line used below.
  always_comb begin
    sync_d = {sync_q[0], rxd_i};
  end

  assign rxs  = sync_q[1];
  assign tick = (cnt_q == '0);

  // Receive FSM. The counter counts down to zero; zero marks a sample point.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          cnt_d   = CNT_HALF;
          state_d = S_START;
        end
      end

      S_START: begin
        if (tick) begin
          if (!rxs) begin
            cnt_d   = CNT_FULL;
            idx_d   = '0;
            state_d = S_DATA;
          end else begin
            // Line already back high at the start-bit centre: glitch.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DATA: begin
        if (tick) begin
          shift_d = {rxs, shift_q[DATA_AMOUNT-1:1]};
          cnt_d   = CNT_FULL;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_STOP: begin
        if (tick) begin
          if (rxs) begin
            word_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_BREAK: begin
        // A line held low must return high before a new start can be seen.
        if (rxs) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Holding register. A consumer accepting in the completion cycle frees the
  // slot in time, so the new word is loaded instead of being counted as lost.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;

    if (word_done) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign busy_o      = (state_q != S_IDLE);
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// tb_uart_rx_stream
//   Directed bench for uart_rx_stream at CLK_KHZ=1000, BODS=100000, which gives
//   DIV=10 and HALF=5. Each serial bit is driven for 10 clocks. A negedge
//   monitor accumulates transfers, pulses and busy cycles. The main sequence
//   compares deltas of those totals, and direct samples, against hand-derived
//   values.
module tb_uart_rx_stream;

  logic       clk_i;
  logic       rst_ni;
  logic       rxd_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       busy_o;
  logic       frame_err_o;
  logic       overrun_o;

  uart_rx_stream #(
    .CLK_KHZ    (1000),
    .BODS       (100000),
    .DATA_AMOUNT(8)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rxd_i      (rxd_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor totals
  int   xfer_cnt   = 0;
  int   xfer_data  = 0;
  int   valid_cyc  = 0;
  int   rise_cyc   = 0;
  int   ferr_cnt   = 0;
  int   ferr_long  = 0;
  int   ovr_cnt    = 0;
  int   ovr_long   = 0;
  int   ovr_cyc    = 0;
  int   busy_cyc   = 0;
  logic valid_prev = 1'b0;
  logic ferr_prev  = 1'b0;
  logic ovr_prev   = 1'b0;

  always @(negedge clk_i) begin
    if (valid_o && ready_i) begin
      xfer_cnt  <= xfer_cnt + 1;
      xfer_data <= int'(data_o);
    end
    if (valid_o) valid_cyc <= valid_cyc + 1;
    if (valid_o && !valid_prev) rise_cyc <= cyc;
    if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
    if (frame_err_o && ferr_prev) ferr_long <= ferr_long + 1;
    if (overrun_o) begin
      ovr_cnt <= ovr_cnt + 1;
      ovr_cyc <= cyc;
    end
    if (overrun_o && ovr_prev) ovr_long <= ovr_long + 1;
    if (busy_o) busy_cyc <= busy_cyc + 1;
    valid_prev <= valid_o;
    ferr_prev  <= frame_err_o;
    ovr_prev   <= overrun_o;
  end

  // Snapshots taken at the start of each scenario
  int s_xfer, s_valid, s_ferr, s_ovr, s_busy;
  int last_start;
  int c0;

  task automatic snap();
    s_xfer  = xfer_cnt;
    s_valid = valid_cyc;
    s_ferr  = ferr_cnt;
    s_ovr   = ovr_cnt;
    s_busy  = busy_cyc;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Start bit, 8 data bits LSB first, stop bit; each held for 10 clocks.
  // last_start is the cycle number right after the edge that drove the start bit.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      #1;
      rxd_i = bits[i];
      if (i == 0) last_start = cyc;
      repeat (9) @(posedge clk_i);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_ni  = 1'b0;
    rxd_i   = 1'b1;
    ready_i = 1'b1;

    // Reset state
    repeat (3) @(negedge clk_i);
    chk("rst_data",  int'(data_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_busy",  int'(busy_o), 0);
    chk("rst_ferr",  int'(frame_err_o), 0);
    chk("rst_ovr",   int'(overrun_o), 0);
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
    idle(5);

    // Single frame 0x46. The line is driven at c0; rxs falls at c0+2; the stop
    // sample comes at c0+2+95; valid is visible at c0+98.
    snap();
    send_frame(8'h46, 1'b1);
    c0 = last_start;
    idle(10);
    chk("f46_xfers",     xfer_cnt - s_xfer, 1);
    chk("f46_data",      xfer_data, 'h46);
    chk("f46_latency",   rise_cyc - c0, 98);
    chk("f46_valid_len", valid_cyc - s_valid, 1);
    chk("f46_ferr",      ferr_cnt - s_ferr, 0);
    chk("f46_ovr",       ovr_cnt - s_ovr, 0);
    @(negedge clk_i);
    chk("f46_valid_low", int'(valid_o), 0);

    // False start: line low 3 cycles. busy spans START for 5 cycles.
    snap();
    @(posedge clk_i);
    #1;
    rxd_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rxd_i = 1'b1;
    idle(30);
    chk("glitch_busy",  busy_cyc - s_busy, 5);
    chk("glitch_xfers", xfer_cnt - s_xfer, 0);
    chk("glitch_valid", valid_cyc - s_valid, 0);
    chk("glitch_ferr",  ferr_cnt - s_ferr, 0);
    chk("glitch_ovr",   ovr_cnt - s_ovr, 0);

    // Framing error on 0x7F, line held low, then a clean frame 0x08
    snap();
    send_frame(8'h7F, 1'b0);
    idle(40);
    chk("ferr_pulses",     ferr_cnt - s_ferr, 1);
    chk("ferr_width",      ferr_long, 0);
    chk("ferr_no_xfer",    xfer_cnt - s_xfer, 0);
    chk("ferr_no_valid",   valid_cyc - s_valid, 0);
    @(negedge clk_i);
    chk("ferr_break_busy", int'(busy_o), 1);
    @(posedge clk_i);
    #1;
    rxd_i = 1'b1;
    idle(20);
    @(negedge clk_i);
    chk("ferr_idle_busy",  int'(busy_o), 0);
    send_frame(8'h08, 1'b1);
    idle(10);
    chk("ferr_next_xfers", xfer_cnt - s_xfer, 1);
    chk("ferr_next_data",  xfer_data, 'h08);
    chk("ferr_total",      ferr_cnt - s_ferr, 1);

    // Overrun: ready low, 0x46 then 0x08 back to back
    ready_i = 1'b0;
    snap();
    send_frame(8'h46, 1'b1);
    c0 = last_start;
    send_frame(8'h08, 1'b1);
    idle(10);
    @(negedge clk_i);
    chk("ovr_valid",  int'(valid_o), 1);
    chk("ovr_data",   int'(data_o), 'h46);
    chk("ovr_pulses", ovr_cnt - s_ovr, 1);
    chk("ovr_width",  ovr_long, 0);
    chk("ovr_time",   ovr_cyc - c0, 198);
    chk("ovr_xfers",  xfer_cnt - s_xfer, 0);
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    idle(3);
    chk("ovr_drain_xfers", xfer_cnt - s_xfer, 1);
    chk("ovr_drain_data",  xfer_data, 'h46);
    @(negedge clk_i);
    chk("ovr_drain_valid", int'(valid_o), 0);

    // Ready pulsed exactly in the stop-sample cycle of the second word (c0+197)
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    idle(5);
    snap();
    fork
      begin
        send_frame(8'h46, 1'b1);
        send_frame(8'h08, 1'b1);
      end
      begin
        @(posedge clk_i);
        #2;
        repeat (197) @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
      end
    join
    idle(10);
    @(negedge clk_i);
    chk("same_valid", int'(valid_o), 1);
    chk("same_data",  int'(data_o), 'h08);
    chk("same_ovr",   ovr_cnt - s_ovr, 0);
    chk("same_xfers", xfer_cnt - s_xfer, 1);
    chk("same_xdata", xfer_data, 'h46);

    // Reset during data bit 3 of 0xFF; the holding register still has 0x08
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(posedge clk_i);
        #2;
        repeat (44) @(posedge clk_i);
        @(negedge clk_i);
        chk("abort_busy_before", int'(busy_o), 1);
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("abort_rst_data",  int'(data_o), 0);
        chk("abort_rst_valid", int'(valid_o), 0);
        chk("abort_rst_busy",  int'(busy_o), 0);
        chk("abort_rst_ferr",  int'(frame_err_o), 0);
        chk("abort_rst_ovr",   int'(overrun_o), 0);
        repeat (2) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
      end
    join
    idle(20);
    ready_i = 1'b1;
    snap();
    chk("abort_no_word", int'(valid_o), 0);
    send_frame(8'h08, 1'b1);
    idle(10);
    chk("abort_xfers", xfer_cnt - s_xfer, 1);
    chk("abort_data",  xfer_data, 'h08);
    chk("abort_ferr",  ferr_cnt - s_ferr, 0);
    @(negedge clk_i);
    chk("abort_data_hold", int'(data_o), 'h08);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_stream.md
Name: uart_rx_stream

Overview:
- Standalone UART receiver: asynchronous serial line in, parallel byte out on a valid/ready stream.
- Receive-direction counterpart to the board transmit path. Key-selected bytes leave on TXD; this block recovers bytes arriving on RXD for the hex display or a downstream consumer.
- Same baud arithmetic as the transmit side. Adds false-start rejection, framing-error and overrun reporting.

Parameters:
- CLK_KHZ, 50000, system clock frequency in kHz.
- BODS, 9600, line baud rate in bit/s.
- DATA_AMOUNT, 8, data bits per frame (5..9), LSB first, no parity, one stop bit.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- rxd_i  in  1  raw serial line, idle high, asynchronous to clk_i.
- data_o  out  DATA_AMOUNT  received word, stable while valid_o=1.
- valid_o  out  1  data_o holds an unconsumed word.
- ready_i  in  1  consumer accepts; transfer occurs when valid_o & ready_i.
- busy_o  out  1  frame reception in progress (FSM not IDLE).
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_o  out  1  one-cycle pulse: completed word dropped because holding register full.

Behaviour:
- Reset (async, rst_ni=0):
  - data_o=0, valid_o=0, busy_o=0, frame_err_o=0, overrun_o=0.
  - Synchronizer flops=1, FSM=IDLE, counters=0.
  - Reset mid-frame abandons the frame; after release the block waits for a fresh falling edge.
- DIV = (CLK_KHZ*1000 + BODS/2) / BODS, integer, computed at elaboration. HALF = DIV/2. Default DIV=5208. Counter width = $clog2(DIV).
- rxd_i passes through a 2-flop synchronizer. All logic uses the synchronized value rxs. Input-to-rxs latency is 2 cycles.
- FSM states:
  - IDLE: rxs=0 -> load counter HALF-1, go START.
  - START: counter reaches 0 -> sample rxs. 0 -> load DIV-1, bit index 0, go DATA. 1 -> false start (glitch), go IDLE, no flags.
  - DATA: each counter expiry samples rxs into shift register (LSB first) and reloads DIV-1. After sample DATA_AMOUNT -> go STOP.
  - STOP: counter expiry samples rxs. 1 -> word complete, go IDLE. 0 -> frame_err_o pulse, word discarded, go BREAK.
  - BREAK: stay until rxs=1, then go IDLE. Line held low never produces extra frames.
- Sample timing: let t be the first cycle rxs=0 in IDLE.
  - Start sampled at t+HALF.
  - Data bit k sampled at t+HALF+(k+1)*DIV.
  - Stop sampled at t+HALF+(DATA_AMOUNT+1)*DIV.
- Output register:
  - On word complete with valid_o=0: data_o<=word and valid_o<=1 on the next edge.
  - valid_o & ready_i with no completion: valid_o<=0. data_o holds its last value.
  - Completion in the same cycle as valid_o & ready_i: new word loaded, valid_o stays 1, no overrun.
  - Completion with valid_o=1 & ready_i=0: new word dropped, data_o unchanged, overrun_o pulses one cycle.
- Completion with a framing error never touches data_o or valid_o.
- busy_o=1 in START, DATA, STOP, BREAK.
- frame_err_o and overrun_o are registered and high exactly one cycle per event.
- Consecutive back-to-back frames: the next start edge can be detected one cycle after the stop sample.

Test Plan (CLK_KHZ=1000, BODS=100000 -> DIV=10, HALF=5; ready_i=1 unless stated):
- Frame 0x46 (start, 0,1,1,0,0,0,1,0, stop) -> valid_o=1 for one cycle, data_o=8'h46. Fires exactly t+5+90+1 cycles after first rxs=0. frame_err_o=0, overrun_o=0.
- rxd_i low for 3 cycles then high -> start sample reads 1, FSM back to IDLE, valid_o stays 0, no flags. busy_o high for 5 cycles.
- Frame 0x7F with stop bit forced 0, line then held low 40 cycles, then high, then frame 0x08 -> frame_err_o single pulse, no valid_o for 0x7F. No spurious frame during the low period. Then valid_o with data_o=8'h08.
- ready_i=0, send 0x46 then 0x08 back to back -> data_o=8'h46, valid_o=1 held. overrun_o pulses once at the second stop sample. Raising ready_i transfers 0x46, then valid_o=0.
- ready_i pulsed in the exact cycle the second word completes -> data_o=8'h08, valid_o stays 1, overrun_o=0.
- rst_ni asserted at data bit 3 of 0xFF, released, then 0x08 sent -> all outputs 0 during reset. No word from the aborted frame. data_o=8'h08 afterward.
